// File: rtl/scale_pkg.sv
// Shared widths and sig encodings for the scale datapath and its scheduler.
package scale_pkg;

  localparam int unsigned IN_W  = 20;
  localparam int unsigned SIG_W = 2;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned OUT_W = 32;

  localparam logic [SIG_W-1:0] SIG_ZERO   = 2'b00;
  localparam logic [SIG_W-1:0] SIG_HALF   = 2'b01;
  localparam logic [SIG_W-1:0] SIG_EIGHTH = 2'b11;
  localparam logic [SIG_W-1:0] SIG_BAD    = 2'b10;

  // The scale unit leaves SIG_BAD undefined, so it is folded onto SIG_ZERO.
  function automatic logic [SIG_W-1:0] sig_remap(input logic [SIG_W-1:0] s);
    return (s == SIG_BAD) ? SIG_ZERO : s;
  endfunction

endpackage

// File: rtl/scale_sched_rr_arbiter.sv
// Round-robin arbiter.
// Ports: clk, rst_n (sync active-low), req (request vector), enable (grant
// permitted), grant (one-hot), grant_idx (index of the granted lane).
// The search starts at rr_ptr; rr_ptr moves past the winner on every grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/scale_sched.sv
// Shares one registered scale unit (1-cycle latency) among NUM_REQ lanes.
// Ports: clk, rst_n (sync active-low); req_valid/req_ready per-lane handshake
// with req_in/req_sig/req_exp operands; sc_in/sc_sig/sc_exp drive the unit,
// sc_out returns its result; res_valid/res_ready/res_data/res_id present the
// head of a 2-entry result buffer; sig_err pulses after a SIG_BAD request.
module scale_sched
  import scale_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IN_W-1:0]  req_in,
  input  logic [NUM_REQ*SIG_W-1:0] req_sig,
  input  logic [NUM_REQ*EXP_W-1:0] req_exp,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IN_W-1:0]          sc_in,
  output logic [SIG_W-1:0]         sc_sig,
  output logic [EXP_W-1:0]         sc_exp,
  input  logic [OUT_W-1:0]         sc_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_W-1:0]         res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     sig_err
);

  logic [IN_W-1:0]  lane_in  [NUM_REQ];
  logic [SIG_W-1:0] lane_sig [NUM_REQ];
  logic [EXP_W-1:0] lane_exp [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_in[i]  = req_in[i*IN_W +: IN_W];
    assign lane_sig[i] = req_sig[i*SIG_W +: SIG_W];
    assign lane_exp[i] = req_exp[i*EXP_W +: EXP_W];
  end

  logic [OUT_W-1:0] data_q [OBUF_DEPTH];
  logic [ID_W-1:0]  id_q   [OBUF_DEPTH];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             in_flight_q;
  logic [ID_W-1:0]  inflight_id_q, inflight_id_d;
  logic             sig_err_q, sig_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win;
  logic [2:0]         occ;
  logic               issue_en, issue, pop, push;

  assign res_valid = (count_q != 2'd0);
  assign pop       = res_valid & res_ready;
  assign push      = in_flight_q;

  // Slots already promised (buffered + in flight) net of this cycle's pop;
  // this is what keeps the 2-entry buffer from ever overflowing.
  assign occ      = 3'(count_q) + 3'(in_flight_q) - 3'(pop);
  assign issue_en = rst_n && (occ < 3'(OBUF_DEPTH));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .enable    (issue_en),
    .grant     (grant),
    .grant_idx (win)
  );

  assign req_ready = grant;
  assign issue     = |grant;

  always_comb begin
    sc_in         = '0;
    sc_sig        = SIG_ZERO;
    sc_exp        = '0;
    sig_err_d     = 1'b0;
    inflight_id_d = inflight_id_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    if (issue) begin
      sc_in         = lane_in[win];
      sc_sig        = sig_remap(lane_sig[win]);
      sc_exp        = lane_exp[win];
      sig_err_d     = (lane_sig[win] == SIG_BAD);
      inflight_id_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      in_flight_q   <= 1'b0;
      inflight_id_q <= '0;
      sig_err_q     <= 1'b0;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= sc_out;
        id_q[wr_ptr_q]   <= inflight_id_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q       <= count_d;
      in_flight_q   <= issue;
      inflight_id_q <= inflight_id_d;
      sig_err_q     <= sig_err_d;
    end
  end

  assign res_data = data_q[rd_ptr_q];
  assign res_id   = id_q[rd_ptr_q];
  assign sig_err  = sig_err_q;

endmodule

// File: tb/tb_scale_sched.sv
module tb_scale_sched;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*20-1:0] req_in;
  logic [N*2-1:0] req_sig;
  logic [N*8-1:0] req_exp;
  logic [19:0]    sc_in;
  logic [1:0]     sc_sig;
  logic [7:0]     sc_exp;
  logic [31:0]    sc_out;
  logic           res_valid, res_ready;
  logic [31:0]    res_data;
  logic [IDW-1:0] res_id;
  logic           sig_err;

  always #5 clk = ~clk;

  scale_sched #(
    .NUM_REQ    (N),
    .ID_W       (IDW),
    .OBUF_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_in    (req_in),
    .req_sig   (req_sig),
    .req_exp   (req_exp),
    .req_ready (req_ready),
    .sc_in     (sc_in),
    .sc_sig    (sc_sig),
    .sc_exp    (sc_exp),
    .sc_out    (sc_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .sig_err   (sig_err)
  );

  // Stand-in for the shared scale unit: registered, output tagged by all operand bits.
  function automatic logic [31:0] unit_f(logic [19:0] a, logic [1:0] s, logic [7:0] e);
    return {s, e, a ^ 20'hA5A5A, 2'b10};
  endfunction

  always @(posedge clk) sc_out <= unit_f(sc_in, sc_sig, sc_exp);

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: every accepted request becomes a result that is visible
  // two cycles later and leaves in acceptance order. At most two results may
  // be outstanding (accepted but not yet consumed) at any time.
  typedef struct {
    logic [31:0] data;
    int          id;
    int          rdy;
  } res_t;

  res_t q[$];
  int   ptr_m;
  int   cyc;
  logic sig_err_exp;

  task automatic eval();
    int         w;
    bit         vis, pop;
    logic [N-1:0] g;
    logic [1:0] s, sr;
    res_t       e;
    #2;
    vis = (q.size() > 0) && (q[0].rdy <= cyc);
    pop = vis && res_ready;
    w   = -1;
    s   = 2'b00;
    if (rst_n && (q.size() - int'(pop)) < 2) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr_m + k) % N;
        if (w < 0 && req_valid[c]) w = c;
      end
    end
    g = '0;
    if (w >= 0) g[w] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(g));
    if (w >= 0) begin
      s  = req_sig[2*w +: 2];
      sr = (s == 2'b10) ? 2'b00 : s;
      check_eq("sc_in", 32'(sc_in), 32'(req_in[20*w +: 20]));
      check_eq("sc_sig", 32'(sc_sig), 32'(sr));
      check_eq("sc_exp", 32'(sc_exp), 32'(req_exp[8*w +: 8]));
    end else begin
      check_eq("sc_idle", {2'b00, sc_in, sc_sig, sc_exp}, 32'd0);
    end
    check_eq("sig_err", 32'(sig_err), 32'(sig_err_exp));
    check_eq("res_valid", 32'(res_valid), 32'(vis));
    if (vis) begin
      check_eq("res_data", res_data, q[0].data);
      check_eq("res_id", 32'(res_id), 32'(q[0].id));
    end
    if (!rst_n) begin
      q.delete();
      ptr_m       = 0;
      sig_err_exp = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (w >= 0) begin
        e.data = unit_f(req_in[20*w +: 20], sr, req_exp[8*w +: 8]);
        e.id   = w;
        e.rdy  = cyc + 2;
        q.push_back(e);
        ptr_m       = (w + 1) % N;
        sig_err_exp = (s == 2'b10);
      end else begin
        sig_err_exp = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int i, logic [19:0] a, logic [1:0] s, logic [7:0] e);
    req_in[20*i +: 20] = a;
    req_sig[2*i +: 2]  = s;
    req_exp[8*i +: 8]  = e;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_lane(i, 20'($urandom), 2'($urandom), 8'($urandom));
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_in      = '0;
    req_sig     = '0;
    req_exp     = '0;
    res_ready   = 1'b1;
    ptr_m       = 0;
    cyc         = 0;
    sig_err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state with every lane requesting: no grant, empty result port.
    req_valid = '1;
    rand_ops();
    cycle();
    check_eq("rst_res_data", res_data, 32'd0);
    check_eq("rst_res_id", 32'(res_id), 32'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    cycle();

    // Single request on lane 2.
    set_lane(2, 20'h80001, 2'b01, 8'h7F);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // All lanes valid, consumer always ready: strict rotation.
    req_valid = '1;
    repeat (12) begin
      rand_ops();
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();

    // Consumer stall with all lanes valid, then release.
    req_valid = '1;
    res_ready = 1'b0;
    repeat (6) cycle();
    res_ready = 1'b1;
    repeat (4) cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Undefined sig on lane 1.
    set_lane(1, 20'h00004, 2'b10, 8'h80);
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Reset one cycle after an issue: in-flight result dropped, pointer to 0.
    req_valid = 4'b0100;
    rand_ops();
    cycle();
    rst_n     = 1'b0;
    req_valid = '1;
    cycle();
    rst_n = 1'b1;
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Lane 3 alone, then lanes 0 and 3: pointer has wrapped to lane 0.
    req_valid = 4'b1000;
    cycle();
    req_valid = 4'b1001;
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Random traffic with random consumer back-pressure.
    repeat (500) begin
      req_valid = N'($urandom);
      rand_ops();
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
